// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

  localparam int XLEN       = 32;
  localparam int INSN_BYTES = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FAULT = 2'd1,
    HALT  = 2'd2
  } state_t;

  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Bundle of redirect, instruction-memory and decode-handshake signals around ifetch.
interface ifetch_if;
  import ifetch_pkg::*;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_en;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_dout;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_fault;

  modport master (
    input  redirect_valid, redirect_pc, imem_dout, out_ready,
    output imem_en, imem_addr, out_valid, out_pc, out_instr, out_fault
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_dout, out_ready,
    input  imem_en, imem_addr, out_valid, out_pc, out_instr, out_fault
  );

endinterface

// File: rtl/ifetch.sv
// Instruction fetch: PC generation, synchronous imem read port and a valid/ready
// response to decode; decode back-pressure is absorbed by holding the memory port.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst,
  ifetch_if.master bus
);

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("ifetch: RESET_PC must be 4-byte aligned");
  end

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic            rsp_valid;

  logic            redirect_aligned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] next_pc;
  logic            present;
  logic            issue;

  always_comb begin
    redirect_aligned = is_aligned(bus.redirect_pc);
    req_addr         = bus.redirect_valid ? {bus.redirect_pc[XLEN-1:2], 2'b00} : fetch_pc;
    next_pc          = req_addr + XLEN'(INSN_BYTES);
    present          = rsp_valid && (state != HALT);
    // A redirect always wins; otherwise only RUN fetches, and only when the slot frees up.
    if (rst) begin
      issue = 1'b0;
    end else if (bus.redirect_valid) begin
      issue = redirect_aligned;
    end else begin
      issue = (state == RUN) && (!rsp_valid || bus.out_ready);
    end
  end

  always_comb begin
    bus.imem_en   = issue;
    bus.imem_addr = rst ? RESET_PC : req_addr;
    bus.out_valid = !rst && present;
    bus.out_pc    = rst ? RESET_PC : rsp_pc;
    bus.out_fault = !rst && (state == FAULT);
    bus.out_instr = (rst || state == FAULT) ? '0 : bus.imem_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      fetch_pc  <= RESET_PC;
      rsp_pc    <= RESET_PC;
      rsp_valid <= 1'b0;
    end else if (bus.redirect_valid) begin
      // Any presented item not accepted this cycle is simply overwritten.
      rsp_valid <= 1'b1;
      if (redirect_aligned) begin
        state    <= RUN;
        rsp_pc   <= req_addr;
        fetch_pc <= next_pc;
      end else begin
        state  <= FAULT;
        rsp_pc <= bus.redirect_pc;
      end
    end else begin
      case (state)
        RUN: begin
          if (issue) begin
            rsp_pc    <= req_addr;
            rsp_valid <= 1'b1;
            fetch_pc  <= next_pc;
          end
        end
        FAULT: begin
          if (present && bus.out_ready) begin
            state     <= HALT;
            rsp_valid <= 1'b0;
          end
        end
        HALT: begin
          rsp_valid <= 1'b0;
        end
        default: begin
          state     <= RUN;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage: generates the program counter, drives the synchronous instruction memory read port (en/addr, 1-cycle read latency, dout held while en low), and presents each fetched instruction with its PC to decode over a valid/ready handshake. Sits between the branch/redirect logic in execute and the decode stage, sustaining one instruction per cycle. A stalled consumer is absorbed by holding the memory read port, so no instruction buffering is needed.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned (elaboration assertion).
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- redirect_valid  in  1  control-flow redirect (branch/jump/trap) this cycle.
- redirect_pc  in  32  redirect target.
- imem_en  out  1  memory read enable.
- imem_addr  out  32  memory byte address; bits [1:0] always 0.
- imem_dout  in  32  memory read data; valid the cycle after an enabled read, held while imem_en=0.
- out_valid  out  1  instruction presented to decode.
- out_ready  in  1  decode accepts.
- out_pc  out  32  PC of presented instruction.
- out_instr  out  32  instruction word (imem_dout pass-through, 0 on fault).
- out_fault  out  1  presented item is an instruction-address-misaligned fault.

## Operation
- Registers: state {RUN, FAULT, HALT}, fetch_pc (next address to request), rsp_valid, rsp_pc.
- Reset: state=RUN, fetch_pc=RESET_PC, rsp_valid=0. During rst: imem_en=0, imem_addr=RESET_PC, out_valid=0, out_fault=0, out_pc=RESET_PC, out_instr=0.
- imem_addr = redirect_valid ? {redirect_pc[31:2],2'b00} : fetch_pc.
- RUN, no redirect: issue (imem_en=1) when !rsp_valid || out_ready. On issue: rsp_pc<=imem_addr, rsp_valid<=1, fetch_pc<=imem_addr+4 (modulo 2^32, wraps 32'hFFFF_FFFC -> 0). No issue: all state held; memory holds dout so the presented item stays stable.
- RUN, redirect, redirect_pc[1:0]==0: in-flight item squashed; issue redirect target same cycle; rsp_valid<=1.
- RUN, redirect, redirect_pc[1:0]!=0: imem_en=0; rsp_pc<=redirect_pc (unmasked); rsp_valid<=1; state<=FAULT.
- out_valid = rsp_valid && state!=HALT; out_pc = rsp_pc; out_fault = (state==FAULT); out_instr = FAULT ? 0 : imem_dout.
- FAULT: imem_en=0; on out_valid&&out_ready -> HALT, rsp_valid<=0.
- HALT: out_valid=0, imem_en=0 until redirect; aligned redirect -> RUN with issue as above; misaligned redirect -> FAULT.
- Redirect in FAULT: aligned -> RUN and issue; misaligned -> stay FAULT with new rsp_pc.
- Simultaneous handshake and redirect: a transfer with out_valid&&out_ready completes (decode keeps it); redirect then overrides all sequential PC updates. With out_ready=0 the presented item is dropped.
- rst asserted mid-operation overrides everything, including redirect_valid.

## Timing
- Redirect (aligned) at cycle t -> out_valid, out_pc=target at t+1; target+4 at t+2 if accepted at t+1.
- Reset released at cycle t (first cycle rst=0) -> imem_en=1, addr=RESET_PC at t; out_valid at t+1.
- Throughput 1 instruction/cycle with out_ready held high.
- Misaligned redirect at t -> fault item at t+1; no memory read issued.
- out_instr/out_valid are combinational from registers and imem_dout only; no path from out_ready to out_valid. imem_en depends combinationally on out_ready and redirect_valid.

## Structure
- Shared package ifetch_pkg: state enum (RUN, FAULT, HALT), INSN_BYTES=4, XLEN=32.
- Flat module; no sub-module is natural (one PC register plus one response register).

## Test plan
- Reset release, RESET_PC=32'h100, out_ready=1, memory preloaded with pattern word = address -> out_pc 0x100,0x104,0x108… each with out_instr equal to out_pc, one per cycle starting 1 cycle after release.
- Stall: drop out_ready for 3 cycles while out_pc=0x108 is presented -> imem_en=0, out_pc/out_instr stable for 3 cycles, then 0x10C follows with no gap and no duplicate.
- Aligned redirect to 0x200 while 0x10C is presented with out_ready=0 -> 0x10C never accepted; next cycle out_pc=0x200; a redirect with out_ready=1 shows the in-flight item accepted before the target.
- Misaligned redirect to 0x202 -> next cycle out_valid=1, out_fault=1, out_pc=0x202, out_instr=0; after accept out_valid=0 and imem_en=0 until aligned redirect to 0x300 resumes fetch.
- Wrap: redirect to 32'hFFFF_FFFC -> next PCs 0xFFFF_FFFC, 0x0000_0000.
- rst asserted mid-stream together with redirect_valid -> out_valid=0 next cycle, and fetch restarts at RESET_PC after release.
